const_imm_fetch: RTL and testbench

Sequencer that decodes the immediate operand of the four `*.const` opcodes (`i32.const`, `i64.const`, `f32.const`, `f64.const`) and pushes the resulting 64-bit value onto the operand stack. It sits between the instruction decoder and the byte-wide program ROM, owning the ROM read port while active. It reads LEB128 or raw little-endian immediate bytes, assembles the value, and hands it to the stack through a valid/ready push port. On completion it returns the address of the next instruction.

---
 rtl/const_imm_fetch.sv | 262 ++++++++++++++++++++++++++
 tb/tb_const_imm_fetch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/const_imm_fetch.sv
// -----------------------------------------------------------------------------
// const_imm_fetch
//
// Decodes the immediate operand of the four *.const opcodes and pushes the
// assembled 64-bit value onto the operand stack.
//
//   0x41 i32.const : signed LEB128, up to 5 bytes, result zero-extended to 64
//   0x42 i64.const : signed LEB128, up to 10 bytes, full 64-bit result
//   0x43 f32.const : 4 raw little-endian bytes, result zero-extended to 64
//   0x44 f64.const : 8 raw little-endian bytes, full 64-bit result
//
// While a fetch is in progress the block owns the byte-wide ROM read port.
// Each immediate byte costs one FETCH cycle (address out) plus one CAPTURE
// cycle (registered ROM data back). Reads are not pipelined.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-low reset
//   start       in   request, accepted only in IDLE
//   opcode      in   opcode byte, valid with start
//   pc_in       in   address of the first immediate byte, valid with start
//   busy        out  fetch in progress (FETCH/CAPTURE/PUSH)
//   rom_rd      out  ROM read strobe
//   rom_addr    out  ROM byte address, valid with rom_rd
//   rom_data    in   ROM byte, valid the cycle after rom_rd
//   push        out  push request to the operand stack
//   push_data   out  value to push, stable while push is held
//   push_ready  in   stack accepts; transfer when push && push_ready
//   done        out  one-cycle completion pulse after the push transfer
//   pc_out      out  address following the immediate, held after done
//   trap        out  0 none, 1 unsupported opcode, 2 LEB128 overrun (sticky)
// -----------------------------------------------------------------------------
module const_imm_fetch #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  busy,
  output logic                  rom_rd,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic                  push,
  output logic [63:0]           push_data,
  input  logic                  push_ready,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [2:0]            trap
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    PUSH    = 3'd3,
    TRAP    = 3'd4
  } state_t;

  localparam logic [7:0] OP_I32 = 8'h41;
  localparam logic [7:0] OP_I64 = 8'h42;
  localparam logic [7:0] OP_F32 = 8'h43;
  localparam logic [7:0] OP_F64 = 8'h44;

  localparam logic [2:0] TRAP_NONE    = 3'd0;
  localparam logic [2:0] TRAP_OPCODE  = 3'd1;
  localparam logic [2:0] TRAP_OVERRUN = 3'd2;

  localparam logic signed [63:0] ALL_ONES = -64'sd1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Sign-extend a finished LEB128 value: every bit at or above the number of
  // payload bits consumed becomes 1. Once 64 or more bits have been consumed
  // there is nothing left to fill.
  function automatic logic [63:0] leb_sign_fill(input logic [63:0] value,
                                                input logic [6:0]  bits_used);
    logic signed [63:0] fill;
    fill = ALL_ONES << bits_used[5:0];
    if (bits_used < 7'd64) begin
      return value | $unsigned(fill);
    end
    return value;
  endfunction

  // Narrow operands (i32/f32) deliver their value in the low word with the
  // upper word cleared; wide operands pass through unchanged.
  function automatic logic [63:0] fit_width(input logic [63:0] value,
                                            input logic        wide);
    if (wide) begin
      return value;
    end
    return {32'h0000_0000, value[31:0]};
  endfunction

  // Registered state
  state_t                  state_q,  state_nxt;
  logic [7:0]              opcode_q, opcode_nxt;
  logic [ADDR_WIDTH-1:0]   ptr_q,    ptr_nxt;
  logic [63:0]             acc_q,    acc_nxt;
  logic [6:0]              shift_q,  shift_nxt;
  logic [3:0]              cnt_q,    cnt_nxt;
  logic [2:0]              trap_q,   trap_nxt;
  logic                    done_q,   done_nxt;
  logic [ADDR_WIDTH-1:0]   pc_out_q, pc_out_nxt;

  // Operand-class decode of the latched opcode
  logic is_leb;
  logic is_wide;
  logic opcode_ok;

  assign is_leb    = (opcode_q == OP_I32) || (opcode_q == OP_I64);
  assign is_wide   = (opcode_q == OP_I64) || (opcode_q == OP_F64);
  assign opcode_ok = (opcode == OP_I32) || (opcode == OP_I64) ||
                     (opcode == OP_F32) || (opcode == OP_F64);

  // Per-byte datapath terms used by CAPTURE
  logic [3:0]  cnt_inc;
  logic [6:0]  shift_inc;
  logic [63:0] raw_placed;
  logic [63:0] leb_payload;
  logic [63:0] leb_acc;
  logic        raw_last;
  logic        leb_at_max;

  assign cnt_inc     = cnt_q + 4'd1;
  assign shift_inc   = shift_q + 7'd7;
  // Raw bytes land at 8 * (bytes already taken); cnt_q never exceeds 7 here.
  assign raw_placed  = {56'd0, rom_data} << {cnt_q[2:0], 3'b000};
  // Payload bits shifted past bit 63 fall off, which is how surplus bits in
  // a final i64 byte are discarded. i32 surplus is removed by fit_width.
  assign leb_payload = {57'd0, rom_data[6:0]} << shift_q;
  assign leb_acc     = acc_q | leb_payload;
  assign raw_last    = (cnt_inc == (is_wide ? 4'd8 : 4'd4));
  assign leb_at_max  = (cnt_inc == (is_wide ? 4'd10 : 4'd5));

  always_comb begin
    state_nxt  = state_q;
    opcode_nxt = opcode_q;
    ptr_nxt    = ptr_q;
    acc_nxt    = acc_q;
    shift_nxt  = shift_q;
    cnt_nxt    = cnt_q;
    trap_nxt   = trap_q;
    done_nxt   = 1'b0;
    pc_out_nxt = pc_out_q;
    busy       = 1'b0;
    rom_rd     = 1'b0;
    rom_addr   = '0;
    push       = 1'b0;
    push_data  = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          opcode_nxt = opcode;
          ptr_nxt    = pc_in;
          acc_nxt    = '0;
          shift_nxt  = '0;
          cnt_nxt    = '0;
          if (opcode_ok) begin
            state_nxt = FETCH;
          end else begin
            trap_nxt  = TRAP_OPCODE;
            state_nxt = TRAP;
          end
        end
      end

      FETCH: begin
        busy      = 1'b1;
        rom_rd    = 1'b1;
        rom_addr  = ptr_q;
        state_nxt = CAPTURE;
      end

      CAPTURE: begin
        busy    = 1'b1;
        ptr_nxt = ptr_q + ADDR_ONE;
        cnt_nxt = cnt_inc;
        if (!is_leb) begin
          if (raw_last) begin
            acc_nxt   = fit_width(acc_q | raw_placed, is_wide);
            state_nxt = PUSH;
          end else begin
            acc_nxt   = acc_q | raw_placed;
            state_nxt = FETCH;
          end
        end else begin
          shift_nxt = shift_inc;
          if (rom_data[7]) begin
            acc_nxt = leb_acc;
            if (leb_at_max) begin
              trap_nxt  = TRAP_OVERRUN;
              state_nxt = TRAP;
            end else begin
              state_nxt = FETCH;
            end
          end else begin
            // Final byte: bit 6 is the sign of the whole encoded value.
            if (rom_data[6]) begin
              acc_nxt = fit_width(leb_sign_fill(leb_acc, shift_inc), is_wide);
            end else begin
              acc_nxt = fit_width(leb_acc, is_wide);
            end
            state_nxt = PUSH;
          end
        end
      end

      PUSH: begin
        busy      = 1'b1;
        push      = 1'b1;
        push_data = acc_q;
        if (push_ready) begin
          done_nxt   = 1'b1;
          pc_out_nxt = ptr_q;
          state_nxt  = IDLE;
        end
      end

      TRAP: begin
        // Terminal until reset; start is ignored and all strobes stay low.
        state_nxt = TRAP;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- state register boundary ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      ptr_q    <= '0;
      acc_q    <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      trap_q   <= TRAP_NONE;
      done_q   <= 1'b0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_nxt;
      opcode_q <= opcode_nxt;
      ptr_q    <= ptr_nxt;
      acc_q    <= acc_nxt;
      shift_q  <= shift_nxt;
      cnt_q    <= cnt_nxt;
      trap_q   <= trap_nxt;
      done_q   <= done_nxt;
      pc_out_q <= pc_out_nxt;
    end
  end

  assign done   = done_q;
  assign pc_out = pc_out_q;
  assign trap   = trap_q;

endmodule

// File: tb/tb_const_imm_fetch.sv
// -----------------------------------------------------------------------------
// tb_const_imm_fetch
//
// Directed bench for const_imm_fetch. Stimulus pushes expected push/done
// transactions into queues; a monitor on the falling edge pops and compares
// them whenever the DUT transfers a push or pulses done. Trap, reset and
// back-pressure behaviour is checked inline by the stimulus thread.
// -----------------------------------------------------------------------------
module tb_const_imm_fetch;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    opcode = 8'h00;
  logic [AW-1:0] pc_in = '0;
  logic          busy;
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data = 8'h00;
  logic          push;
  logic [63:0]   push_data;
  logic          push_ready = 1'b1;
  logic          done;
  logic [AW-1:0] pc_out;
  logic [2:0]    trap;

  logic [7:0] rom [0:255];

  int cyc = 0;
  int rd_cnt = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0]   data;
    logic [AW-1:0] pc;
    int            t0;
    int            xfer;
    int            dn;
  } exp_t;

  exp_t push_q[$];
  exp_t done_q[$];
  exp_t mon_p;
  exp_t mon_d;

  const_imm_fetch #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .opcode     (opcode),
    .pc_in      (pc_in),
    .busy       (busy),
    .rom_rd     (rom_rd),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .push       (push),
    .push_data  (push_data),
    .push_ready (push_ready),
    .done       (done),
    .pc_out     (pc_out),
    .trap       (trap)
  );

  always #5 clk = ~clk;

  // Registered ROM model and cycle counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rom_rd) begin
      rom_data <= rom[rom_addr[7:0]];
      rd_cnt   <= rd_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      if (push && push_ready) begin
        if (push_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_push: got push of %h, expected no push (cycle %0d)", push_data, cyc);
        end else begin
          mon_p = push_q.pop_front();
          check("push_data", push_data, mon_p.data);
          check("push_cycle", 64'(cyc - mon_p.t0), 64'(mon_p.xfer));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done with pc_out %h, expected none (cycle %0d)", pc_out, cyc);
        end else begin
          mon_d = done_q.pop_front();
          check("pc_out", 64'(pc_out), 64'(mon_d.pc));
          check("done_cycle", 64'(cyc - mon_d.t0), 64'(mon_d.dn));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive start for one cycle (this cycle is T0); returns in T1.
  task automatic issue(input logic [7:0] op, input logic [AW-1:0] pc,
                       input bit expect_result, input logic [63:0] data,
                       input logic [AW-1:0] pc_end, input int xfer);
    exp_t e;
    start  = 1'b1;
    opcode = op;
    pc_in  = pc;
    if (expect_result) begin
      e.data = data;
      e.pc   = pc_end;
      e.t0   = cyc;
      e.xfer = xfer;
      e.dn   = xfer + 1;
      push_q.push_back(e);
      done_q.push_back(e);
    end
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 200) begin
      tick(1);
      k++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: done stayed 0 for 200 cycles, expected a pulse", name);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      64'(busy),     64'd0);
    check({tag, "_rom_rd"},    64'(rom_rd),   64'd0);
    check({tag, "_push"},      64'(push),     64'd0);
    check({tag, "_done"},      64'(done),     64'd0);
    check({tag, "_trap"},      64'(trap),     64'd0);
    check({tag, "_rom_addr"},  64'(rom_addr), 64'd0);
    check({tag, "_push_data"}, push_data,     64'd0);
    check({tag, "_pc_out"},    64'(pc_out),   64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int rd0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[11] = 8'hC0;                                        // f64 at 4..11
    rom[20] = 8'hE5; rom[21] = 8'h8E; rom[22] = 8'h26;      // i64 0x98765
    rom[30] = 8'h80; rom[31] = 8'h7F;                       // i64 -128
    rom[40] = 8'h7F;                                        // i32 -1
    rom[60] = 8'h00; rom[61] = 8'h00; rom[62] = 8'h80; rom[63] = 8'h3F; // f32 1.0
    for (int i = 50; i < 55; i++) rom[i] = 8'hFF;           // i32 overrun

    // Reset state
    reset = 1'b0;
    tick(3);
    check_all_zero("reset");
    reset = 1'b1;
    tick(1);

    // f64 immediate
    issue(8'h44, 32'd4, 1'b1, 64'hC000_0000_0000_0000, 32'd12, 17);
    check("f64_busy_t1", 64'(busy), 64'd1);
    check("f64_rom_rd_t1", 64'(rom_rd), 64'd1);
    check("f64_rom_addr_t1", 64'(rom_addr), 64'd4);
    wait_done("f64");
    check("f64_busy_in_done", 64'(busy), 64'd0);
    check("f64_trap", 64'(trap), 64'd0);

    // i64 multi-byte positive, then negative
    issue(8'h42, 32'd20, 1'b1, 64'h0000_0000_0009_8765, 32'd23, 7);
    wait_done("i64_pos");
    issue(8'h42, 32'd30, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 32'd32, 5);
    wait_done("i64_neg");

    // f32 with 5 cycles of back-pressure
    push_ready = 1'b0;
    issue(8'h43, 32'd60, 1'b1, 64'h0000_0000_3F80_0000, 32'd64, 14);
    w = 0;
    while (!push && w < 50) begin
      tick(1);
      w++;
    end
    check("f32_push_first_cycle", 64'(w + 1), 64'd9);
    for (int i = 0; i < 5; i++) begin
      check("f32_stall_push", 64'(push), 64'd1);
      check("f32_stall_data", push_data, 64'h0000_0000_3F80_0000);
      check("f32_stall_done", 64'(done), 64'd0);
      tick(1);
    end
    push_ready = 1'b1;
    wait_done("f32");

    // Back-to-back: start in the done cycle of the f32 fetch
    issue(8'h41, 32'd40, 1'b1, 64'h0000_0000_FFFF_FFFF, 32'd41, 3);
    check("b2b_busy_t1", 64'(busy), 64'd1);
    wait_done("i32_neg");

    // Reset in the middle of an f64 fetch (asserted during T6)
    issue(8'h44, 32'd4, 1'b0, 64'd0, 32'd0, 0);
    tick(5);
    reset = 1'b0;
    tick(1);
    check_all_zero("midreset");
    reset = 1'b1;
    tick(1);
    issue(8'h44, 32'd4, 1'b1, 64'hC000_0000_0000_0000, 32'd12, 17);
    wait_done("f64_after_reset");

    // Unsupported opcode trap
    rd0 = rd_cnt;
    issue(8'h45, 32'd0, 1'b0, 64'd0, 32'd0, 0);
    check("trap1_code_t1", 64'(trap), 64'd1);
    check("trap1_busy_t1", 64'(busy), 64'd0);
    check("trap1_rom_rd_t1", 64'(rom_rd), 64'd0);
    tick(3);
    issue(8'h44, 32'd4, 1'b0, 64'd0, 32'd0, 0);
    check("trap1_start_ignored", 64'(busy), 64'd0);
    tick(20);
    check("trap1_no_reads", 64'(rd_cnt - rd0), 64'd0);
    check("trap1_sticky", 64'(trap), 64'd1);
    reset = 1'b0;
    tick(1);
    check("trap1_cleared", 64'(trap), 64'd0);
    reset = 1'b1;
    tick(1);

    // LEB128 overrun: fifth byte still has the continuation bit
    issue(8'h41, 32'd50, 1'b0, 64'd0, 32'd0, 0);
    tick(9);
    check("trap2_not_early", 64'(trap), 64'd0);
    tick(1);
    check("trap2_code", 64'(trap), 64'd2);
    check("trap2_busy", 64'(busy), 64'd0);
    tick(2);
    issue(8'h44, 32'd4, 1'b0, 64'd0, 32'd0, 0);
    check("trap2_start_ignored", 64'(busy), 64'd0);
    tick(20);
    check("trap2_sticky", 64'(trap), 64'd2);
    check("trap2_no_push", 64'(push), 64'd0);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);

    check("pending_pushes", 64'(push_q.size()), 64'd0);
    check("pending_dones", 64'(done_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
